// File: rtl/alu64_pkg.sv
// Shared ALU-64 constants and the sequential adder's state encoding.
// States are plain 2-bit constants so legacy tools and waveforms stay readable.
package alu64_pkg;

  localparam int ALU_WIDTH = 64;
  localparam int SLICE_W   = 8;
  localparam int NSLICE    = ALU_WIDTH / SLICE_W;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Signed overflow of the top slice: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic z_msb);
    return (a_msb == b_msb) && (z_msb != a_msb);
  endfunction

endpackage

// File: rtl/csea_level.sv
// Combinational 8-bit carry-select adder slice: low nibble ripples, high nibble
// is precomputed for both carry-ins and selected by the low nibble's carry.
module csea_level
  import alu64_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               previous_c_out,
  output logic [SLICE_W-1:0] z,
  output logic               next_c_out
);

  localparam int HALF = SLICE_W / 2;

  logic [HALF:0] lo_sum;
  logic [HALF:0] hi_sum0;
  logic [HALF:0] hi_sum1;

  always_comb begin
    lo_sum  = {1'b0, x[HALF-1:0]} + {1'b0, y[HALF-1:0]} + {{HALF{1'b0}}, previous_c_out};
    hi_sum0 = {1'b0, x[SLICE_W-1:HALF]} + {1'b0, y[SLICE_W-1:HALF]};
    hi_sum1 = {1'b0, x[SLICE_W-1:HALF]} + {1'b0, y[SLICE_W-1:HALF]} + {{HALF{1'b0}}, 1'b1};
  end

  assign z          = {(lo_sum[HALF] ? hi_sum1[HALF-1:0] : hi_sum0[HALF-1:0]), lo_sum[HALF-1:0]};
  assign next_c_out = lo_sum[HALF] ? hi_sum1[HALF] : hi_sum0[HALF];

endmodule

// File: rtl/csea_seq_adder64.sv
// Multi-cycle 64-bit add/subtract: one csea_level byte per cycle, LSB first,
// with the byte carry registered between cycles. Start accepted only in IDLE.
module csea_seq_adder64
  import alu64_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  localparam int NSL  = WIDTH / SLICE;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSL - 1);

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] slice_x;
  logic [SLICE-1:0] slice_y;
  logic [SLICE-1:0] slice_z;
  logic             slice_co;

  assign slice_x = a_q[idx_q*SLICE +: SLICE];
  assign slice_y = b_q[idx_q*SLICE +: SLICE];

  csea_level u_level (
    .x              (slice_x),
    .y              (slice_y),
    .previous_c_out (carry_q),
    .z              (slice_z),
    .next_c_out     (slice_co)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // Subtraction is a + ~b + 1: invert B once here, seed the carry with 1.
        if (start) begin
          a_d      = a;
          b_d      = op_sub ? ~b : b;
          carry_d  = op_sub;
          idx_d    = '0;
          result_d = '0;
          c_out_d  = 1'b0;
          ovf_d    = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[idx_q*SLICE +: SLICE] = slice_z;
        carry_d = slice_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          c_out_d = slice_co;
          ovf_d   = add_ovf(a_q[WIDTH-1], b_q[WIDTH-1], slice_z[SLICE-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule
